// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write/read/scoreboard bus between the core pipeline (master) and regfile_sb (slave)
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int AW = $clog2(NREG)
);
  logic wen;
  logic [AW-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0] rbusy;
  logic sb_set;
  logic [AW-1:0] sb_addr;
  modport master(output wen, waddr, wdata, raddr, sb_set, sb_addr, input rdata, rbusy);
  modport slave(input wen, waddr, wdata, raddr, sb_set, sb_addr, output rdata, rbusy);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NRD read ports, one write port, optional bypass and busy scoreboard; ports clk, rst_n, bus (slave), busy_cnt, ret_value, regs
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  parameter int RET_IDX = 10
) (
  input logic clk,
  input logic rst_n,
  regfile_sb_if.slave bus,
  output logic [$clog2(NREG+1)-1:0] busy_cnt,
  output logic [XLEN-1:0] ret_value,
  output logic [NREG*XLEN-1:0] regs
);
  localparam int CW = $clog2(NREG+1);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic wr, set, inc, dec;
  always_comb begin
    wr = bus.wen && !(ZERO_REG != 0 && bus.waddr == '0);
    set = bus.sb_set && !(ZERO_REG != 0 && bus.sb_addr == '0);
    inc = set && !busy[bus.sb_addr];
    dec = bus.wen && busy[bus.waddr] && !(set && bus.sb_addr == bus.waddr);
    busy_nxt = busy;
    if (bus.wen) busy_nxt[bus.waddr] = 1'b0;
    if (set) busy_nxt[bus.sb_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf <= '{default: '0};
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr) rf[bus.waddr] <= bus.wdata;
      busy <= busy_nxt;
      busy_cnt <= busy_cnt + CW'(inc) - CW'(dec);
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic z, f;
    assign a = bus.raddr[i*AW +: AW];
    assign z = ZERO_REG != 0 && a == '0;
    assign f = BYPASS != 0 && bus.wen && bus.waddr == a;
    assign bus.rdata[i*XLEN +: XLEN] = z ? '0 : f ? bus.wdata : rf[a];
    assign bus.rbusy[i] = !z && !f && busy[a];
  end
  for (genvar r = 0; r < NREG; r++) begin : g_regs
    assign regs[r*XLEN +: XLEN] = rf[r];
  end
  assign ret_value = rf[RET_IDX];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb against a behavioural register/busy model
module tb_regfile_sb;
  localparam int XLEN = 32, NREG = 32, AW = 5, NRD = 2, CW = 6, RET = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  logic [CW-1:0] busy_cnt;
  logic [XLEN-1:0] ret_value;
  logic [NREG*XLEN-1:0] regs;
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1), .RET_IDX(RET)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_cnt(busy_cnt), .ret_value(ret_value), .regs(regs)
  );
  logic [XLEN-1:0] m_rf [NREG];
  logic [NREG-1:0] m_busy;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) m_rf[r] <= '0;
      m_busy <= '0;
    end else begin
      if (bus.wen && bus.waddr != 0) m_rf[bus.waddr] <= bus.wdata;
      if (bus.wen) m_busy[bus.waddr] <= 1'b0;
      if (bus.sb_set && bus.sb_addr != 0) m_busy[bus.sb_addr] <= 1'b1;
    end
  typedef struct {
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0] rb;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] ret;
    int ri;
    logic [XLEN-1:0] rv;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t predict(int ri);
    exp_t e;
    logic [AW-1:0] a;
    int n;
    n = 0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.raddr[i*AW +: AW];
      if (a == 0) begin
        e.rd[i*XLEN +: XLEN] = '0;
        e.rb[i] = 1'b0;
      end else if (bus.wen && bus.waddr == a) begin
        e.rd[i*XLEN +: XLEN] = bus.wdata;
        e.rb[i] = 1'b0;
      end else begin
        e.rd[i*XLEN +: XLEN] = m_rf[a];
        e.rb[i] = m_busy[a];
      end
    end
    for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
    e.cnt = CW'(n);
    e.ret = m_rf[RET];
    e.ri = ri;
    e.rv = m_rf[ri];
    return e;
  endfunction
  task automatic drive(logic wen, int waddr, logic [XLEN-1:0] wdata, int ra0, int ra1, logic sset, int saddr);
    bus.wen = wen;
    bus.waddr = AW'(waddr);
    bus.wdata = wdata;
    bus.raddr = {AW'(ra1), AW'(ra0)};
    bus.sb_set = sset;
    bus.sb_addr = AW'(saddr);
  endtask
  task automatic chk_now(int ri);
    exp_t g;
    q.push_back(predict(ri));
    #1;
    g = q.pop_front();
    check("rdata0", 64'(bus.rdata[0 +: XLEN]), 64'(g.rd[0 +: XLEN]));
    check("rdata1", 64'(bus.rdata[XLEN +: XLEN]), 64'(g.rd[XLEN +: XLEN]));
    check("rbusy", 64'(bus.rbusy), 64'(g.rb));
    check("busy_cnt", 64'(busy_cnt), 64'(g.cnt));
    check("ret_value", 64'(ret_value), 64'(g.ret));
    check("regs", 64'(regs[g.ri*XLEN +: XLEN]), 64'(g.rv));
  endtask
  task automatic step(int ri);
    chk_now(ri);
    @(negedge clk);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(0);
    rst_n = 1'b1;
    drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0); step(5);
    drive(0, 0, 0, 5, 0, 0, 0); step(5);
    check("r5_written", 64'(regs[5*XLEN +: XLEN]), 64'hDEADBEEF);
    drive(0, 0, 0, 5, 0, 1, 6); chk_now(5);
    rst_n = 1'b0;
    #1;
    chk_now(5);
    check("rst_rdata", 64'(bus.rdata[0 +: XLEN]), 64'h0);
    @(negedge clk);
    drive(1, 5, 32'h11111111, 5, 0, 1, 3);
    @(negedge clk);
    drive(0, 0, 0, 5, 3, 0, 0); step(5);
    rst_n = 1'b1;
    drive(1, 0, 32'h1234, 0, 0, 0, 0); step(0);
    drive(0, 0, 0, 0, 0, 0, 0); step(0);
    drive(1, 10, 32'hCAFE0001, 10, 3, 0, 0); step(10);
    drive(0, 0, 0, 10, 3, 0, 0); step(10);
    check("ret_value_r10", 64'(ret_value), 64'hCAFE0001);
    drive(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0); step(7);
    drive(0, 0, 0, 7, 7, 0, 0); step(7);
    drive(0, 0, 0, 3, 4, 1, 3); step(3);
    drive(0, 0, 0, 3, 4, 1, 4); step(3);
    drive(0, 0, 0, 3, 4, 0, 0); step(3);
    drive(1, 3, 32'h33, 3, 4, 0, 0); step(3);
    drive(0, 0, 0, 3, 4, 0, 0); step(3);
    drive(0, 0, 0, 3, 4, 1, 3); step(3);
    drive(0, 0, 0, 3, 4, 0, 0); step(3);
    drive(1, 3, 32'h44, 3, 4, 1, 3); step(3);
    drive(0, 0, 0, 3, 4, 0, 0); step(3);
    drive(0, 0, 0, 0, 3, 1, 0); step(0);
    drive(0, 0, 0, 0, 3, 0, 0); step(0);
    drive(1, 4, 32'h55, 4, 5, 1, 5); step(4);
    drive(0, 0, 0, 4, 5, 0, 0); step(4);
    for (int r = 1; r < NREG; r++) begin
      drive(0, 0, 0, r, r - 1, 1, r); step(r);
    end
    drive(0, 0, 0, 1, 31, 1, 1); step(1);
    check("sat_cnt", 64'(busy_cnt), 64'd31);
    for (int r = 1; r < NREG; r++) begin
      drive(1, r, $urandom, r, r + 1 < NREG ? r + 1 : 1, 0, 0); step(r);
    end
    drive(1, 1, 32'h77, 2, 1, 0, 0); step(1);
    drive(0, 0, 0, 1, 2, 0, 0); step(1);
    check("drain_cnt", 64'(busy_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
